// File: rtl/pe_link_pkg.sv
// Shared link constants for the east ingress path.
// Link word layout is {valid, last, payload}.
package pe_link_pkg;

  localparam int LINK_VALID_BIT   = 129;
  localparam int LINK_LAST_BIT    = 128;
  localparam int LINK_PAYLOAD_MSB = 127;

  localparam int PE_LINK_WIDTH      = LINK_VALID_BIT + 1;
  localparam int PE_PAYLOAD_WIDTH   = LINK_PAYLOAD_MSB + 1;
  localparam int PE_FIFO_ADDR_BITS  = 7;
  localparam int PE_FIFO_DEPTH      = 1 << PE_FIFO_ADDR_BITS;
  localparam int PE_PKT_CNT_WIDTH   = 16;

  typedef logic [LINK_VALID_BIT:0] link_word_t;

endpackage

// File: rtl/pe_link_fifo_ram.sv
// Simple dual-port storage for the ingress FIFO.
// Synchronous write, asynchronous (LUTRAM-style) read.
module pe_link_fifo_ram #(
  parameter int WIDTH     = 129,
  parameter int ADDR_BITS = 7
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [1 << ADDR_BITS];

  // Write port; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pe_east_ingress_fifo.sv
// Buffers a leaf operator stream and drives the
// free-running link word into the PE tile.
module pe_east_ingress_fifo
  import pe_link_pkg::*;
#(
  parameter int EAST_WIDTH         = PE_LINK_WIDTH,
  parameter int PAYLOAD_WIDTH      = PE_PAYLOAD_WIDTH,
  parameter int NUM_BRAM_ADDR_BITS = PE_FIFO_ADDR_BITS,
  parameter int PKT_CNT_WIDTH      = PE_PKT_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ap_start,
  input  logic [PAYLOAD_WIDTH-1:0]      s_data,
  input  logic                          s_last,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [EAST_WIDTH-1:0]         out_to_east,
  output logic [NUM_BRAM_ADDR_BITS:0]   fifo_count,
  output logic [PKT_CNT_WIDTH-1:0]      pkt_count
);

  localparam int AW = NUM_BRAM_ADDR_BITS;
  localparam int WW = PAYLOAD_WIDTH + 1;
  localparam logic [AW:0] FULL = (AW + 1)'(1 << AW);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [WW-1:0] rd_word;
  logic          push;
  logic          pop;

  // Full/empty come from the registered count only.
  assign s_ready = (fifo_count != FULL) && !reset;
  assign push    = s_valid && s_ready;
  assign pop     = ap_start && (fifo_count != '0);

  pe_link_fifo_ram #(
    .WIDTH     (WW),
    .ADDR_BITS (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({s_last, s_data}),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  // Pointers, occupancy, link register and packet counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      pkt_count   <= '0;
      out_to_east <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        out_to_east <= {1'b1, rd_word};
        if (rd_word[WW-1]) begin
          pkt_count <= pkt_count + 1'b1;
        end
      end else if (ap_start) begin
        out_to_east[EAST_WIDTH-1] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_east_ingress_fifo.sv
// Scoreboard bench for the east ingress FIFO.
// Stimulus queues expected words; monitor checks pops.
module tb_pe_east_ingress_fifo;

  logic         clk = 1'b0;
  logic         reset;
  logic         ap_start;
  logic [127:0] s_data;
  logic         s_last;
  logic         s_valid;
  logic         s_ready;
  logic [129:0] out_to_east;
  logic [7:0]   fifo_count;
  logic [15:0]  pkt_count;

  int total = 0;
  int bad   = 0;

  logic [128:0] sb [$];
  logic [129:0] held;
  int           c0;

  pe_east_ingress_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .ap_start    (ap_start),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .out_to_east (out_to_east),
    .fifo_count  (fifo_count),
    .pkt_count   (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [129:0] act,
                     input logic [129:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: with ap_start high at an edge, valid=1 means a pop.
  always @(posedge clk) begin
    logic a;
    logic r;
    logic [128:0] e;
    a = ap_start;
    r = reset;
    #1;
    if (!r && a && out_to_east[129]) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", out_to_east, '0);
      end else begin
        e = sb.pop_front();
        chk("sb_word", out_to_east, {1'b1, e});
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic l,
                      input int exp_cnt);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    if (exp_cnt >= 0) begin
      chk("cnt_steady", 130'(fifo_count), 130'(exp_cnt));
    end
    while (!s_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      chk("send_timeout", 130'(s_ready), 130'(1));
    end else begin
      sb.push_back({l, d});
    end
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    while (fifo_count != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 130'(fifo_count), 130'(0));
  endtask

  initial begin
    reset    = 1'b1;
    ap_start = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    s_valid  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 130'(s_ready), 130'(0));
    reset    = 1'b0;
    ap_start = 1'b1;

    // Idle after reset.
    repeat (10) begin
      @(negedge clk);
      chk("idle_out", out_to_east, '0);
      chk("idle_rdy", 130'(s_ready), 130'(1));
      chk("idle_cnt", 130'(fifo_count), 130'(0));
      chk("idle_pkt", 130'(pkt_count), 130'(0));
    end

    // 3-word packet with latency checks.
    @(negedge clk);
    s_valid = 1'b1; s_data = 128'hA; s_last = 1'b0;
    sb.push_back({1'b0, 128'hA});
    @(negedge clk);
    chk("lat_e0", out_to_east, '0);
    s_data = 128'hB;
    sb.push_back({1'b0, 128'hB});
    @(negedge clk);
    chk("pk_a", out_to_east, {2'b10, 128'hA});
    s_data = 128'hC; s_last = 1'b1;
    sb.push_back({1'b1, 128'hC});
    @(negedge clk);
    chk("pk_b", out_to_east, {2'b10, 128'hB});
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("pk_c", out_to_east, {2'b11, 128'hC});
    @(negedge clk);
    chk("pk_idle", out_to_east, {2'b01, 128'hC});
    chk("pk_cnt1", 130'(pkt_count), 130'(1));

    // Fill to full with ap_start low, then drain.
    ap_start = 1'b0;
    held = out_to_east;
    for (int i = 0; i < 128; i++) begin
      send(128'(i), i == 127, -1);
    end
    idle_in();
    chk("full_cnt", 130'(fifo_count), 130'(128));
    chk("full_rdy", 130'(s_ready), 130'(0));
    chk("full_hold", out_to_east, held);
    ap_start = 1'b1;
    @(negedge clk);
    chk("drain_cnt", 130'(fifo_count), 130'(127));
    chk("drain_rdy", 130'(s_ready), 130'(1));
    wait_empty("drain_empty");
    @(negedge clk);
    chk("drain_pkt", 130'(pkt_count), 130'(2));
    chk("drain_tail", out_to_east, {2'b01, 128'd127});

    // Continuous push/pop across pointer wraps.
    for (int i = 0; i < 300; i++) begin
      send(128'h1000 + 128'(i), i == 299, (i == 0) ? -1 : 1);
    end
    idle_in();
    wait_empty("wrap_empty");
    @(negedge clk);
    chk("wrap_pkt", 130'(pkt_count), 130'(3));

    // Freeze mid-drain.
    ap_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(128'h2000 + 128'(i), 1'b0, -1);
    end
    idle_in();
    ap_start = 1'b1;
    repeat (3) @(negedge clk);
    ap_start = 1'b0;
    held = out_to_east;
    c0 = int'(fifo_count);
    chk("frz_cnt0", 130'(c0), 130'(7));
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk("frz_out", out_to_east, held);
      chk("frz_cnt", 130'(fifo_count),
          130'(c0 + ((j - 1) < 2 ? (j - 1) : 2)));
      if (j <= 2) begin
        s_valid = 1'b1;
        s_data  = 128'h3000 + 128'(j);
        s_last  = (j == 2);
        sb.push_back({(j == 2), 128'h3000 + 128'(j)});
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
    end
    ap_start = 1'b1;
    wait_empty("frz_empty");
    @(negedge clk);
    chk("frz_pkt", 130'(pkt_count), 130'(4));

    // Reset mid-packet with 40 words buffered.
    ap_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      send(128'h4000 + 128'(i), 1'b0, -1);
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("pre_rst_cnt", 130'(fifo_count), 130'(40));
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rst_out", out_to_east, '0);
    chk("rst_cnt", 130'(fifo_count), 130'(0));
    chk("rst_pkt", 130'(pkt_count), 130'(0));
    chk("rst_rdy0", 130'(s_ready), 130'(0));
    reset    = 1'b0;
    ap_start = 1'b1;
    @(negedge clk);
    chk("rst_rdy1", 130'(s_ready), 130'(1));
    send(128'h55, 1'b1, -1);
    idle_in();
    @(negedge clk);
    chk("post_rst_out", out_to_east, {2'b11, 128'h55});
    chk("post_rst_pkt", 130'(pkt_count), 130'(1));
    repeat (3) @(negedge clk);
    chk("sb_drained", 130'(sb.size()), 130'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_east_ingress_fifo.md
Name: pe_east_ingress_fifo

Overview:
- Upstream neighbour of the empty/pass-through PE tile.
- Accepts a valid/ready packet stream from a leaf operator and buffers it in a FIFO of 2^NUM_BRAM_ADDR_BITS entries.
- Emits free-running 130-bit link words on `out_to_east`; this bus connects to the tile's `in_from_east`.
- Pops are gated by `ap_start`, matching the tile: when `ap_start` is low, the link holds its value.

Parameters:
- EAST_WIDTH, 130, link word width; fixed as {valid[129], last[128], payload[127:0]}.
- PAYLOAD_WIDTH, 128, stream data width; must equal EAST_WIDTH-2.
- NUM_BRAM_ADDR_BITS, 7, FIFO address bits; depth = 128.
- PKT_CNT_WIDTH, 16, width of the completed-packet counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ap_start  input  1  run enable; pops occur only while high
- s_data  input  PAYLOAD_WIDTH  stream payload
- s_last  input  1  marks the final word of a packet
- s_valid  input  1  producer has a word
- s_ready  output  1  FIFO can accept a word
- out_to_east  output  EAST_WIDTH  link word toward the PE tile
- fifo_count  output  NUM_BRAM_ADDR_BITS+1  current occupancy, 0..128
- pkt_count  output  PKT_CNT_WIDTH  packets fully emitted since reset

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge clk.
  - Reset is synchronous and active-high.
  - On reset: out_to_east=0, fifo_count=0, pkt_count=0, rd_ptr=wr_ptr=0.
  - s_ready=0 during the reset cycle and 1 on the first cycle after.
  - Memory contents are not cleared.
  - Reset mid-packet discards all buffered words. No partial-packet recovery; the producer restarts.
- Push:
  - s_ready = (fifo_count != 2^NUM_BRAM_ADDR_BITS) and not reset; this is a registered-count decision.
  - push = s_valid & s_ready; it writes {s_last, s_data} at wr_ptr.
  - wr_ptr increments modulo depth, wrapping 127 -> 0.
  - s_data/s_last must stay stable while s_valid=1 and s_ready=0.
- Pop:
  - pop = ap_start & (fifo_count != 0).
  - On a pop edge, out_to_east <= {1'b1, mem[rd_ptr]} and rd_ptr increments modulo depth.
  - Memory read is asynchronous (LUTRAM-style), so the word is captured in the same edge.
- Idle:
  - ap_start=1 and the FIFO is empty: out_to_east[129] <= 0; bits [128:0] hold their previous value.
  - ap_start=0: out_to_east holds all 130 bits (valid included), no pop, pushes continue.
- Latency: a word accepted at edge E0 appears on out_to_east after edge E1 if ap_start=1 and it is at the FIFO head.
- Occupancy:
  - fifo_count <= fifo_count + push - pop.
  - Simultaneous push and pop leaves the count unchanged, including at count 1.
  - Push when full cannot happen, because s_ready=0.
  - Pop when empty cannot happen.
  - Full with a concurrent pop: s_ready stays 0 that cycle, since it is computed from the registered count. One-cycle bubble accepted.
- Ordering: the FIFO is strictly in order; no reordering or dropping.
- pkt_count:
  - Increments on each pop whose popped word has last=1.
  - Wraps at 2^PKT_CNT_WIDTH silently.
- Pointer width: NUM_BRAM_ADDR_BITS bits. Full/empty are derived only from fifo_count, never from pointer comparison.

Decomposition:
- Shared package `pe_link_pkg`:
  - LINK_VALID_BIT=129, LINK_LAST_BIT=128, LINK_PAYLOAD_MSB=127.
  - Link word typedef (130 bits).
  - Helper constant PE_FIFO_DEPTH.
- One sub-module, `pe_link_fifo_ram`:
  - Simple dual-port memory, (PAYLOAD_WIDTH+1) x 2^NUM_BRAM_ADDR_BITS.
  - Synchronous write, asynchronous read.
- Top level holds the pointers, count, pop/push logic, output register and packet counter.
- Expected size: ~150-220 lines total.

Test Plan:
- Reset, then idle, ap_start=1: out_to_east=0, s_ready=1, fifo_count=0, pkt_count=0 for 10 cycles.
- Push 3-word packet {0xA, 0xB, 0xC(last)} back-to-back, ap_start=1: out_to_east = {1,0,0xA}, {1,0,0xB}, {1,1,0xC} on consecutive cycles starting 1 cycle after the first accept. Then bit129=0 with payload 0xC held; pkt_count=1.
- ap_start=0, push 128 words 0..127: fifo_count=128, s_ready=0, out_to_east unchanged. Then ap_start=1: drains 0..127 in order over 128 cycles; s_ready returns to 1 the cycle after the first pop (count=127).
- Pointer wrap: push/pop 300 words continuously with simultaneous push and pop: fifo_count stable at 1, output sequence intact across the 127->0 wrap.
- Toggle ap_start low for 5 cycles mid-drain: out_to_east frozen with bit129 unchanged, fifo_count only rises with pushes; resuming continues with the next word, no loss or duplicate.
- Assert reset with fifo_count=40 mid-packet: next cycle out_to_east=0, fifo_count=0, pkt_count=0; a subsequent 1-word packet emits correctly after 1 cycle.
